// File: rtl/chesssoc_pio_in_irq.sv
// Avalon-MM parallel input port with per-bit edge capture and a maskable level interrupt.
// Optional two-flop input synchroniser enabled by defining CHESSSOC_PIO_IN_SYNC_EN.
module chesssoc_pio_in_irq #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      readdata_d;
    logic             wr_en;
    logic             unused_writedata;

`ifdef CHESSSOC_PIO_IN_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    assign data_in = sync2_q;
`else
    assign data_in = in_port;
`endif

    assign wr_en            = chipselect & ~write_n;
    assign unused_writedata = ^writedata;

    // Unsupported EDGE_TYPE values fall back to rising-edge capture.
    always_comb begin
        edge_det = data_in & ~prev_q;
        case (EDGE_TYPE)
            1:       edge_det = ~data_in & prev_q;
            2:       edge_det = data_in ^ prev_q;
            default: edge_det = data_in & ~prev_q;
        endcase
    end

    always_comb begin
        irqmask_d = irqmask_q;
        clr_mask  = '0;
        if (wr_en) begin
            case (address)
                2'd2:    irqmask_d = writedata[WIDTH-1:0];
                2'd3:    clr_mask  = writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        // A new edge in the same cycle as its clear keeps the bit set.
        edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(data_in);
            2'd2:    readdata_d = 32'(irqmask_q);
            2'd3:    readdata_d = 32'(edgecap_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q    <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            readdata  <= '0;
        end else begin
            prev_q    <= data_in;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            readdata  <= readdata_d;
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: doc/chesssoc_pio_in_irq.md
CHESSSOC_PIO_IN_IRQ -- requirements
Module: chesssoc_pio_in_irq

Interface
REQ-001 Parameter WIDTH, default 8: input port width, legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge-capture mode; 0 = rising, 1 = falling, 2 = any.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 address  in  2  Avalon-MM register select: 0 data, 2 irqmask, 3 edgecapture (1 reserved).
REQ-006 chipselect  in  1  slave select; qualifies write only.
REQ-007 write_n  in  1  active-low write strobe.
REQ-008 writedata  in  32  write data, bits [WIDTH-1:0] used.
REQ-009 in_port  in  WIDTH  external inputs, asynchronous to clk.
REQ-010 readdata  out  32  registered read data, upper bits zero.
REQ-011 irq  out  1  level interrupt request, active-high.

Function
REQ-012 Read: readdata updated every cycle from address (no chipselect qualification), read latency 1 cycle.
REQ-013 Address 0 returns data_in; 2 returns irqmask; 3 returns edgecapture; 1 returns 0.
REQ-014 Write occurs when chipselect=1 and write_n=0; writes to 0 and 1 are ignored.
REQ-015 Write to 2 loads irqmask <= writedata[WIDTH-1:0].
REQ-016 Write to 3 clears each edgecapture bit whose writedata bit is 1 (write-1-to-clear); 0 bits unchanged.
REQ-017 prev <= data_in every cycle; edge[i] = data_in[i]&~prev[i] (0), ~data_in[i]&prev[i] (1), data_in[i]^prev[i] (2).
REQ-018 edgecapture[i] set to 1 on cycle edge[i]=1 and holds until cleared.
REQ-019 Simultaneous edge[i] and clear of bit i: set wins, bit remains 1.
REQ-020 irq = |(edgecapture & irqmask), combinational from registers, no extra latency.
REQ-021 Changing irqmask affects irq the cycle after the write; captured bits are not lost when masked.
REQ-022 EDGE_TYPE outside 0..2 behaves as 0.

Reset
REQ-023 When reset_n=0 at a clk edge: readdata, irqmask, edgecapture, prev and synchroniser stages <= 0.
REQ-024 irq is 0 during and the cycle after reset; no edge registered in first cycle after reset release beyond REQ-017 rules with prev=0.
REQ-025 Reset asserted mid-operation discards pending captures and any coincident write.

Configuration
REQ-026 Macro CHESSSOC_PIO_IN_SYNC_EN defined: data_in is in_port through a 2-flop synchroniser; in_port change before edge k visible at address 0 read of edge k+2, edgecapture/irq set after edge k+2.
REQ-027 Macro not defined: data_in = in_port directly; change before edge k sets edgecapture after edge k and appears in readdata after edge k.

Verification
REQ-028 Reset with in_port=8'hFF held -> readdata=0, irq=0; after release, address 0 read -> 8'hFF (latency per REQ-026/027).
REQ-029 EDGE_TYPE=0, irqmask=8'h01, in_port 8'h00->8'h01 -> edgecapture=8'h01, irq=1; write 3 with 8'h01 -> edgecapture=0, irq=0 next cycle.
REQ-030 EDGE_TYPE=0, in_port 8'h03->8'h00 -> edgecapture stays 8'h00; EDGE_TYPE=2 same stimulus -> 8'h03.
REQ-031 irqmask=0, rising edge bit 4 -> edgecapture=8'h10, irq=0; write irqmask=8'h10 -> irq=1 next cycle.
REQ-032 Write-1-to-clear bit 2 in the same cycle a new rising edge occurs on bit 2 -> edgecapture[2] remains 1.
REQ-033 WIDTH=1: read address 0 returns 32'h00000001 with in_port=1; address 1 read returns 0; writes to addresses 0/1 leave state unchanged.
